// File: rtl/key_expand_pkg.sv
// Shared definitions for the AES-128 key schedule engine: round count, FSM states, rcon.
package key_expand_pkg;

  localparam int AES_NROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_expand_if.sv
// Request/readback bundle between the key schedule and its add_rkey consumers.
interface key_expand_if;
  logic [127:0] key_in;
  logic         start;
  logic [3:0]   addr;
  logic [127:0] rkey;
  logic         busy;
  logic         valid;

  modport master (output key_in, start, addr, input rkey, busy, valid);
  modport slave  (input key_in, start, addr, output rkey, busy, valid);
endinterface

// File: rtl/key_expand_sbox.sv
// Combinational AES forward S-box; entry 0 sits in the most significant byte of the table.
module key_expand_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ~a == 255 - a, so this picks the byte for entry a counting from the top.
  logic [10:0] idx;
  assign idx = {~a, 3'b000};
  assign y   = TBL[idx +: 8];

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule: captures a cipher key on start and derives round keys 1..10,
// one per clock, into an 11-entry store read combinationally by round address.
module key_expand
  import key_expand_pkg::*;
#(
  parameter int NROUNDS = AES_NROUNDS
) (
  input logic        clk,
  input logic        rst,
  key_expand_if.slave bus
);

  state_t       state;
  logic [3:0]   round;
  logic         busy_q;
  logic         valid_q;
  logic [127:0] rk [0:NROUNDS];

  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t;
  logic [31:0]  w0n, w1n, w2n, w3n;

  assign prev_idx = round - 4'd1;
  assign prev_key = (round != 4'd0 && round <= 4'(NROUNDS)) ? rk[prev_idx] : '0;

  assign rot_w3 = {prev_key[23:0], prev_key[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    key_expand_sbox u_sbox (
      .a (rot_w3[8*i +: 8]),
      .y (sub_w3[8*i +: 8])
    );
  end

  assign t        = sub_w3 ^ {rcon(round), 24'h0};
  assign w0n      = prev_key[127:96] ^ t;
  assign w1n      = prev_key[95:64]  ^ w0n;
  assign w2n      = prev_key[63:32]  ^ w1n;
  assign w3n      = prev_key[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      round   <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i <= NROUNDS; i++) rk[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            rk[0]   <= bus.key_in;
            round   <= 4'd1;
            state   <= ST_EXPAND;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        ST_EXPAND: begin
          // start is deliberately not looked at here: an expansion always runs to completion.
          rk[round] <= next_key;
          round     <= round + 4'd1;
          if (round == 4'(NROUNDS)) begin
            state   <= ST_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.rkey  = (bus.addr <= 4'(NROUNDS)) ? rk[bus.addr] : '0;

endmodule

// File: tb/tb_key_expand.sv
// Bench for key_expand: FIPS-197 vectors plus random keys against a word-level
// key-expansion model whose S-box is derived from GF(2^8) inversion.
module tb_key_expand;

  logic clk;
  logic rst;
  key_expand_if bus();

  key_expand dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk   [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_ref[temp[31:24]], sbox_ref[temp[23:16]],
                sbox_ref[temp[15:8]],  sbox_ref[temp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the accepting edge T.
  task automatic do_start(input logic [127:0] key);
    bus.key_in = key;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({bus.busy, bus.valid} !== 2'b00)
      $display("FAIL reset_flags busy/valid=%b expected 00", {bus.busy, bus.valid});
    else n_pass++;
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      #1;
      n_checks++;
      if (bus.rkey !== 128'h0)
        $display("FAIL reset_rkey addr=%0d got=%h expected=0", a, bus.rkey);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips();
    model_expand(FIPS_KEY);
    do_start(FIPS_KEY);
    n_checks++;
    if ({bus.busy, bus.valid} !== 2'b10)
      $display("FAIL fips_accept busy/valid=%b expected 10", {bus.busy, bus.valid});
    else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if ({bus.busy, bus.valid} !== ((k == 10) ? 2'b01 : 2'b10))
        $display("FAIL fips_timing edge=T+%0d busy/valid=%b expected %b", k,
                 {bus.busy, bus.valid}, (k == 10) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    bus.addr = 4'd1; #1;
    n_checks++;
    if (bus.rkey !== FIPS_RK1) $display("FAIL fips_rk1 got=%h expected=%h", bus.rkey, FIPS_RK1);
    else n_pass++;
    bus.addr = 4'd10; #1;
    n_checks++;
    if (bus.rkey !== FIPS_RK10) $display("FAIL fips_rk10 got=%h expected=%h", bus.rkey, FIPS_RK10);
    else n_pass++;
    bus.addr = 4'd0; #1;
    n_checks++;
    if (bus.rkey !== FIPS_KEY) $display("FAIL fips_rk0 got=%h expected=%h", bus.rkey, FIPS_KEY);
    else n_pass++;
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a); #1;
      n_checks++;
      if (bus.rkey !== ((a <= 10) ? exp_rk[a] : 128'h0))
        $display("FAIL fips_model addr=%0d got=%h expected=%h", a, bus.rkey,
                 (a <= 10) ? exp_rk[a] : 128'h0);
      else n_pass++;
    end
  endtask

  task automatic test_zero_key();
    model_expand(128'h0);
    do_start(128'h0);
    for (int k = 1; k <= 10; k++) tick();
    n_checks++;
    if ({bus.busy, bus.valid} !== 2'b01)
      $display("FAIL zero_done busy/valid=%b expected 01", {bus.busy, bus.valid});
    else n_pass++;
    bus.addr = 4'd1; #1;
    n_checks++;
    if (bus.rkey !== ZERO_RK1) $display("FAIL zero_rk1 got=%h expected=%h", bus.rkey, ZERO_RK1);
    else n_pass++;
    bus.addr = 4'd10; #1;
    n_checks++;
    if (bus.rkey !== ZERO_RK10) $display("FAIL zero_rk10 got=%h expected=%h", bus.rkey, ZERO_RK10);
    else n_pass++;
    for (int a = 0; a <= 10; a++) begin
      bus.addr = 4'(a); #1;
      n_checks++;
      if (bus.rkey !== exp_rk[a])
        $display("FAIL zero_model addr=%0d got=%h expected=%h", a, bus.rkey, exp_rk[a]);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    model_expand(FIPS_KEY);
    do_start(FIPS_KEY);
    for (int k = 1; k <= 3; k++) tick();
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      tick();
      n_checks++;
      if ({bus.busy, bus.valid} !== ((k == 10) ? 2'b01 : 2'b10))
        $display("FAIL ignore_timing edge=T+%0d busy/valid=%b expected %b", k,
                 {bus.busy, bus.valid}, (k == 10) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    for (int a = 0; a <= 10; a++) begin
      bus.addr = 4'(a); #1;
      n_checks++;
      if (bus.rkey !== exp_rk[a])
        $display("FAIL ignore_keys addr=%0d got=%h expected=%h", a, bus.rkey, exp_rk[a]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] key;
    do_start(FIPS_KEY);
    for (int k = 1; k <= 5; k++) tick();
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.valid} !== 2'b00)
      $display("FAIL areset_flags busy/valid=%b expected 00", {bus.busy, bus.valid});
    else n_pass++;
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a); #1;
      n_checks++;
      if (bus.rkey !== 128'h0)
        $display("FAIL areset_rkey addr=%0d got=%h expected=0", a, bus.rkey);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key);
    do_start(key);
    for (int k = 1; k <= 10; k++) tick();
    n_checks++;
    if ({bus.busy, bus.valid} !== 2'b01)
      $display("FAIL areset_resume busy/valid=%b expected 01", {bus.busy, bus.valid});
    else n_pass++;
    for (int a = 0; a <= 10; a++) begin
      bus.addr = 4'(a); #1;
      n_checks++;
      if (bus.rkey !== exp_rk[a])
        $display("FAIL areset_keys addr=%0d got=%h expected=%h", a, bus.rkey, exp_rk[a]);
      else n_pass++;
    end
  endtask

  task automatic test_restart_done();
    model_expand(128'h0);
    do_start(128'h0);
    n_checks++;
    if ({bus.busy, bus.valid} !== 2'b10)
      $display("FAIL restart_drop busy/valid=%b expected 10", {bus.busy, bus.valid});
    else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if ({bus.busy, bus.valid} !== ((k == 10) ? 2'b01 : 2'b10))
        $display("FAIL restart_timing edge=T+%0d busy/valid=%b expected %b", k,
                 {bus.busy, bus.valid}, (k == 10) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    bus.addr = 4'd1; #1;
    n_checks++;
    if (bus.rkey !== ZERO_RK1) $display("FAIL restart_rk1 got=%h expected=%h", bus.rkey, ZERO_RK1);
    else n_pass++;
    bus.addr = 4'd10; #1;
    n_checks++;
    if (bus.rkey !== ZERO_RK10) $display("FAIL restart_rk10 got=%h expected=%h", bus.rkey, ZERO_RK10);
    else n_pass++;
  endtask

  task automatic test_random_keys();
    logic [127:0] key;
    for (int n = 0; n < 4; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      do_start(key);
      for (int k = 1; k <= 10; k++) tick();
      n_checks++;
      if ({bus.busy, bus.valid} !== 2'b01)
        $display("FAIL rand_done run=%0d busy/valid=%b expected 01", n, {bus.busy, bus.valid});
      else n_pass++;
      for (int a = 0; a < 16; a++) begin
        bus.addr = 4'(a); #1;
        n_checks++;
        if (bus.rkey !== ((a <= 10) ? exp_rk[a] : 128'h0))
          $display("FAIL rand_keys run=%0d addr=%0d got=%h expected=%h", n, a, bus.rkey,
                   (a <= 10) ? exp_rk[a] : 128'h0);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.key_in = '0;
    bus.addr   = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_start_ignored();
    test_async_reset();
    test_restart_done();
    test_random_keys();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
